pwm_led_ctrl: RTL and testbench

PWM LED pattern controller, directly downstream of the UART mode-control/clock-divider top. Consumes the start flag, command byte and 1 Hz tick that top exports, and drives an 8-LED bank. Modes: fixed brightness, breathing ramp and one-hot chase. Brightness changes are glitch-free: the duty shadow updates only at PWM period boundaries.

---
 rtl/pwm_led_pkg.sv | 24 ++
 rtl/pwm_gen.sv | 32 +++
 rtl/pwm_led_ctrl.sv | 123 ++++++++++++
 tb/tb_pwm_led_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pwm_led_pkg.sv
// Shared types and constants for the PWM LED pattern controller.
// Imported by pwm_gen and pwm_led_ctrl.
package pwm_led_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIXED,
        ST_BRE_UP,
        ST_BRE_DN,
        ST_CHASE
    } state_t;

    localparam logic [1:0] MODE_FIXED   = 2'b00;
    localparam logic [1:0] MODE_BREATHE = 2'b01;
    localparam logic [1:0] MODE_CHASE   = 2'b10;
    localparam logic [1:0] MODE_OFF     = 2'b11;

    localparam int DEF_STEP = 16;

    function automatic logic isBreathe(input state_t s);
        return (s == ST_BRE_UP) || (s == ST_BRE_DN);
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with a period-boundary duty shadow.
// The shadow only reloads on wrap so a duty change never truncates a period.
module pwm_gen #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                force_off,
    output logic                pwm,
    output logic [PWM_BITS-1:0] duty_q
);

    logic [PWM_BITS-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            duty_q <= '0;
            pwm    <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (force_off) begin
                duty_q <= '0;
            end else if (cnt == '1) begin
                duty_q <= duty;
            end
            pwm <= !force_off && (cnt < duty_q);
        end
    end

endmodule

// File: rtl/pwm_led_ctrl.sv
// Mode FSM (fixed / breathe / chase) driving an LED bank through pwm_gen.
// Breathing ramp and chase position advance on the 1 Hz tick.
module pwm_led_ctrl
    import pwm_led_pkg::*;
#(
    parameter int PWM_BITS = 8,
    parameter int LED_N    = 8,
    parameter int STEP     = DEF_STEP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iSTART,
    input  logic [7:0]       iData,
    input  logic             iTick,
    output logic             oPWM,
    output logic [LED_N-1:0] oLED,
    output logic [7:0]       oDuty
);

    localparam logic [8:0] STEP9 = 9'(STEP);

    state_t              state;
    state_t              target;
    logic [8:0]          bDuty;
    logic [LED_N-1:0]    pos;
    logic [1:0]          mode;
    logic [8:0]          ceil9;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] dutyQ;
    logic                forceOff;

    assign mode  = iData[7:6];
    assign ceil9 = {1'b0, iData[5:0], 2'b00};

    // Breathing keeps its current direction while the mode stays breathe.
    always_comb begin
        target = ST_IDLE;
        if (iSTART) begin
            case (mode)
                MODE_FIXED:   target = ST_FIXED;
                MODE_BREATHE: target = isBreathe(state) ? state : ST_BRE_UP;
                MODE_CHASE:   target = ST_CHASE;
                default:      target = ST_IDLE;
            endcase
        end
    end

    // A group change takes priority over a tick landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            bDuty <= '0;
            pos   <= LED_N'(1);
        end else if (target != state) begin
            state <= target;
            bDuty <= '0;
            pos   <= LED_N'(1);
        end else if (iTick) begin
            case (state)
                ST_BRE_UP: begin
                    if (bDuty + STEP9 >= ceil9) begin
                        bDuty <= ceil9;
                        state <= ST_BRE_DN;
                    end else begin
                        bDuty <= bDuty + STEP9;
                    end
                end
                ST_BRE_DN: begin
                    if (bDuty > ceil9) begin
                        bDuty <= ceil9;
                    end else if (bDuty <= STEP9) begin
                        bDuty <= '0;
                        state <= ST_BRE_UP;
                    end else begin
                        bDuty <= bDuty - STEP9;
                    end
                end
                ST_CHASE: begin
                    pos <= {pos[LED_N-2:0], pos[LED_N-1]};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        duty = '0;
        case (state)
            ST_FIXED,
            ST_CHASE:  duty = PWM_BITS'(ceil9[7:0]);
            ST_BRE_UP,
            ST_BRE_DN: duty = PWM_BITS'(bDuty[7:0]);
            default:   duty = '0;
        endcase
    end

    assign forceOff = (state == ST_IDLE);

    pwm_gen #(
        .PWM_BITS(PWM_BITS)
    ) uGen (
        .clk      (clk),
        .reset    (reset),
        .duty     (duty),
        .force_off(forceOff),
        .pwm      (oPWM),
        .duty_q   (dutyQ)
    );

    assign oDuty = 8'(dutyQ);

    always_comb begin
        oLED = '0;
        case (state)
            ST_FIXED,
            ST_BRE_UP,
            ST_BRE_DN: oLED = {LED_N{oPWM}};
            ST_CHASE:  oLED = pos & {LED_N{oPWM}};
            default:   oLED = '0;
        endcase
    end

endmodule

// File: tb/tb_pwm_led_ctrl.sv
// Directed bench for pwm_led_ctrl: fixed, breathe, chase,
// glitch-free duty update, stop, reset and mode/tick collision.
module tb_pwm_led_ctrl;
    import pwm_led_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       iSTART;
    logic [7:0] iData;
    logic       iTick;
    logic       oPWM;
    logic [7:0] oLED;
    logic [7:0] oDuty;

    int errs = 0;
    int checks = 0;

    pwm_led_ctrl #(
        .PWM_BITS(8),
        .LED_N   (8),
        .STEP    (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .iSTART(iSTART),
        .iData (iData),
        .iTick (iTick),
        .oPWM  (oPWM),
        .oLED  (oLED),
        .oDuty (oDuty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic waitCnt(input logic [7:0] v);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (dut.uGen.cnt != v && n < 600);
        if (dut.uGen.cnt != v) chk("waitCnt", int'(dut.uGen.cnt), int'(v));
    endtask

    task automatic tick();
        iTick = 1'b1;
        @(negedge clk);
        iTick = 1'b0;
    endtask

    // Samples one full output period (compares made at cnt 0..255).
    task automatic measure(input logic [7:0] pat, input int flipAt,
                           input logic [7:0] flipData,
                           output int highs, output int bad);
        waitCnt(8'd1);
        highs = 0;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (i > 0) @(negedge clk);
            if (oPWM) highs++;
            if (oLED !== (oPWM ? pat : 8'h00)) bad++;
            if (flipAt >= 0 && int'(dut.uGen.cnt) == flipAt) iData = flipData;
        end
    endtask

    int hi;
    int bad;
    int expB;

    initial begin
        reset = 1'b1;
        iSTART = 1'b0;
        iData = 8'h00;
        iTick = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstPWM", int'(oPWM), 0);
        chk("rstLED", int'(oLED), 0);
        chk("rstDuty", int'(oDuty), 0);
        chk("rstPos", int'(dut.pos), 1);
        chk("rstBduty", int'(dut.bDuty), 0);
        reset = 1'b0;

        // Fixed level 64, then glitch-free change to 252 at cnt=100
        iSTART = 1'b1;
        iData = 8'h10;
        waitCnt(8'd128);
        measure(8'hFF, -1, 8'h00, hi, bad);
        chk("fixHigh", hi, 64);
        chk("fixLed", bad, 0);
        chk("fixDuty", int'(oDuty), 64);
        measure(8'hFF, 100, 8'h3F, hi, bad);
        chk("glitchCur", hi, 64);
        measure(8'hFF, -1, 8'h00, hi, bad);
        chk("glitchNext", hi, 252);
        chk("glitchLed", bad, 0);

        // Ceiling 0 never drives high
        iData = 8'h00;
        waitCnt(8'd128);
        measure(8'hFF, -1, 8'h00, hi, bad);
        chk("zeroHigh", hi, 0);

        // Breathe with ceiling 252: 0,16..240,252,236..12,0
        iData = 8'h7F;
        waitCnt(8'd128);
        waitCnt(8'd0);
        chk("breStart", int'(oDuty), 0);
        for (int i = 1; i <= 32; i++) begin
            if (i <= 15) expB = 16 * i;
            else if (i == 16) expB = 252;
            else if (i <= 31) expB = 252 - 16 * (i - 16);
            else expB = 0;
            tick();
            waitCnt(8'd10);
            waitCnt(8'd0);
            chk($sformatf("bre%0d", i), int'(oDuty), expB);
        end
        chk("breDir", int'(dut.state), int'(ST_BRE_UP));

        // Stop mid-breathe
        tick();
        tick();
        waitCnt(8'd10);
        waitCnt(8'd40);
        chk("preStop", int'(dut.bDuty), 32);
        iSTART = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("stopLED", int'(oLED), 0);
        chk("stopPWM", int'(oPWM), 0);
        chk("stopDuty", int'(oDuty), 0);
        chk("stopBduty", int'(dut.bDuty), 0);

        // Chase at level 252, three ticks
        iSTART = 1'b1;
        iData = 8'hBF;
        repeat (2) @(negedge clk);
        tick();
        tick();
        tick();
        chk("chasePos", int'(dut.pos), 8'h08);
        waitCnt(8'd128);
        measure(8'h08, -1, 8'h00, hi, bad);
        chk("chaseHigh", hi, 252);
        chk("chaseLed", bad, 0);

        // Reset mid-chase
        reset = 1'b1;
        @(negedge clk);
        chk("rcPWM", int'(oPWM), 0);
        chk("rcLED", int'(oLED), 0);
        chk("rcDuty", int'(oDuty), 0);
        chk("rcPos", int'(dut.pos), 1);
        reset = 1'b0;

        // Mode change 00->10 with a tick in the same cycle
        iData = 8'h10;
        repeat (3) @(negedge clk);
        iData = 8'h90;
        tick();
        chk("colPos", int'(dut.pos), 1);
        chk("colState", int'(dut.state), int'(ST_CHASE));
        waitCnt(8'd128);
        measure(8'h01, -1, 8'h00, hi, bad);
        chk("colHigh", hi, 64);
        chk("colLed", bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
